sync_fifo: RTL and testbench

- Single-clock synchronous FIFO buffering 8-bit data words between a producer (write port) and a consumer (read port).
- Sits between two blocks in the same clock domain.
- Exposes full/empty status so both sides can apply backpressure.
- Also provides an occupancy count and sticky-free error pulses for overflow and underflow attempts.

---
 rtl/sync_fifo_pkg.sv | 9 +
 rtl/sync_fifo_mem.sv | 32 +++
 rtl/sync_fifo.sv | 75 +++++++
 tb/tb_sync_fifo.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  typedef logic [7:0] fifo_data_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: synchronous write port, registered read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is never cleared; reset only discards it through the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a same-address read at full returns the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, full/empty flags and
// one-cycle overflow/underflow pulses around a dual-port storage array.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come straight from the registered count, never from the requests.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A read at full frees the slot the same-cycle write lands in.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and randomized bench for sync_fifo against a queue-based model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       full, empty, overflow, underflow;
  logic [4:0] count;

  int vectors = 0;
  int miscompares = 0;

  fifo_data_t q[$];
  fifo_data_t m_rdata = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string where);
    chk({where, ".count"},     32'(count),     32'(q.size()));
    chk({where, ".full"},      32'(full),      32'(q.size() == DEPTH));
    chk({where, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({where, ".rdata"},     32'(rdata),     32'(m_rdata));
    chk({where, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({where, ".underflow"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata = 8'h00;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // Drive one cycle's request 1 unit after an edge, then check 1 unit after the next edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input string where);
    bit rd_ok, wr_ok;
    wr_en = w;
    rd_en = r;
    wdata = d;
    @(posedge clk);
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < DEPTH) || rd_ok);
    if (rd_ok) m_rdata = q.pop_front();
    if (wr_ok) q.push_back(d);
    m_ovf = w && !wr_ok;
    m_udf = r && !rd_ok;
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_all(where);
  endtask

  initial begin
    logic [7:0] pat;
    model_reset();
    @(posedge clk);
    #1;
    chk_all("por");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), "pre_rst_wr");
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk);
    #1;
    chk_all("rst_held");
    rst = 1'b0;
    cyc(1'b0, 1'b1, 8'h00, "udf_after_rst");

    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i), "fill");
    cyc(1'b1, 1'b0, 8'hAA, "ovf");
    cyc(1'b0, 1'b0, 8'h00, "ovf_clear");
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00, "drain");
    cyc(1'b0, 1'b1, 8'h00, "udf_empty");
    cyc(1'b0, 1'b0, 8'h00, "udf_clear");

    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i), "refill");
    cyc(1'b1, 1'b1, 8'h55, "simul_full");
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00, "drain_55");
    chk("last_is_55", 32'(rdata), 32'h55);
    cyc(1'b1, 1'b1, 8'h55, "simul_empty");
    cyc(1'b0, 1'b1, 8'h00, "read_55");

    pat = 8'h80;
    for (int i = 0; i < 40; i++) begin
      if ((i % 6) < 3) begin
        cyc(1'b1, 1'b0, pat, "wrap_wr");
        pat++;
      end else begin
        cyc(1'b0, 1'b1, 8'h00, "wrap_rd");
      end
      chk("wrap_le3", 32'(count <= 5'd3), 32'd1);
    end

    for (int i = 0; i < 400; i++) begin
      logic w, r;
      w = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
      cyc(w, r, 8'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
